iq_capture_scheduler: RTL

IQ_CAPTURE_SCHEDULER -- requirements
Module: iq_capture_scheduler

---
 rtl/iq_capture_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/iq_capture_scheduler.sv
// iq_capture_scheduler
// Captures the first WIN and last WIN samples of each I and Q packet into a
// single-write-port buffer. A round-robin arbiter merges the two sample
// streams. The buffer is read back through a registered port outside capture.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   pkt_len             : samples per channel per packet, latched at arm
//   arm, abort          : start / terminate a capture (single-cycle)
//   i_valid/i_data      : I sample offer, i_ready accepts it
//   q_valid/q_data      : Q sample offer, q_ready accepts it
//   busy, done          : state flags (CAPTURE, DONE)
//   cfg_err             : one-cycle pulse on a rejected arm
//   cap_count           : completed captures, wrapping
//   rd_en/rd_addr       : buffer read request
//   rd_valid/rd_data    : read response, one cycle after rd_en
module iq_capture_scheduler #(
   parameter  int DW  = 12,
   parameter  int WIN = 64,
   localparam int AW  = $clog2(4*WIN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   pkt_len,
   input  logic          arm,
   input  logic          abort,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          i_ready,
   input  logic          q_valid,
   input  logic [DW-1:0] q_data,
   output logic          q_ready,
   output logic          busy,
   output logic          done,
   output logic          cfg_err,
   output logic [7:0]    cap_count,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data
);

   localparam int IW = AW - 1;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

   state_t        state;
   logic [15:0]   len_q;
   logic [15:0]   i_cnt;
   logic [15:0]   q_cnt;
   logic          ptr;            // 0 = I has priority, 1 = Q
   logic [DW-1:0] mem [4*WIN];

   logic          cap;
   logic          i_req;
   logic          q_req;
   logic [15:0]   i_cnt_nxt;
   logic [15:0]   q_cnt_nxt;
   logic          all_done;
   logic          len_ok;
   logic [15:0]   wr_c;
   logic [15:0]   tail_start;
   logic [15:0]   tail_idx;
   logic          in_head;
   logic          in_tail;
   logic [IW-1:0] wr_idx;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   // Arbitration: a channel requests only while capturing and incomplete.
   assign cap     = (state == S_CAPTURE);
   assign i_req   = cap && i_valid && (i_cnt != len_q);
   assign q_req   = cap && q_valid && (q_cnt != len_q);
   assign i_ready = i_req && (!q_req || !ptr);
   assign q_ready = q_req && (!i_req || ptr);

   assign i_cnt_nxt = i_cnt + {15'd0, i_ready};
   assign q_cnt_nxt = q_cnt + {15'd0, q_ready};
   assign all_done  = (i_cnt_nxt == len_q) && (q_cnt_nxt == len_q);
   assign len_ok    = (pkt_len >= 16'(2*WIN));

   // Head window keeps count c at index c; the tail window is packed right
   // after it. Middle samples are counted but dropped. len_q >= 2*WIN, so
   // tail_start never underflows.
   assign wr_c       = q_ready ? q_cnt : i_cnt;
   assign tail_start = len_q - 16'(WIN);
   assign tail_idx   = 16'(WIN) + (wr_c - tail_start);
   assign in_head    = (wr_c < 16'(WIN));
   assign in_tail    = (wr_c >= tail_start);
   assign wr_idx     = in_head ? wr_c[IW-1:0] : tail_idx[IW-1:0];
   assign wr_en      = (i_ready || q_ready) && (in_head || in_tail);
   assign wr_addr    = {q_ready, wr_idx};
   assign wr_data    = q_ready ? q_data : i_data;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         len_q     <= '0;
         i_cnt     <= '0;
         q_cnt     <= '0;
         ptr       <= 1'b0;
         cap_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         cfg_err  <= 1'b0;
         rd_valid <= 1'b0;
         // Reads are refused during capture so they never meet a write.
         if (rd_en && !cap) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_addr];
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else if (arm) begin
                  if (len_ok) begin
                     state <= S_CAPTURE;
                     len_q <= pkt_len;
                     i_cnt <= '0;
                     q_cnt <= '0;
                     ptr   <= 1'b0;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_CAPTURE: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  i_cnt <= i_cnt_nxt;
                  q_cnt <= q_cnt_nxt;
                  // Pointer moves only on a contested grant.
                  if (i_req && q_req) ptr <= !ptr;
                  if (all_done) begin
                     state     <= S_DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     cap_count <= cap_count + 8'd1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
